// File: rtl/pixel_pkg.sv
// Frame geometry and sequencing states for the pixel frame buffer.
// Shared with the inference engine.
package pixel_pkg;

  localparam int FRAME_ROWS  = 28;
  localparam int FRAME_COLS  = 28;
  localparam int FRAME_DEPTH = FRAME_ROWS * FRAME_COLS;
  localparam int FRAME_AW    = $clog2(FRAME_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    STREAM,
    DONE
  } state_t;

endpackage

// File: rtl/pixel_frame_stream_if.sv
// Raster pixel stream handshake: one beat per valid & ready.
// The frame buffer drives master, the inference engine is slave.
interface pixel_frame_stream_if
  import pixel_pkg::*;
#(
  parameter int PIX_W = 1,
  parameter int AW    = FRAME_AW
);

  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_data;
  logic [AW-1:0]    out_index;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/pixel_frame_stream_frame_ram.sv
// Simple dual-port pixel RAM, one write port, one registered read.
// A read colliding with a write to the same address sees old data.
module frame_ram #(
  parameter int PIX_W = 1,
  parameter int DEPTH = 784,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pixel_frame_stream.sv
// Frame buffer: random-address pixel writes, hardware clear and
// raster stream-out through a 2-entry skid buffer.
module pixel_frame_stream
  import pixel_pkg::*;
#(
  parameter  int PIX_W = 1,
  parameter  int ROWS  = FRAME_ROWS,
  parameter  int COLS  = FRAME_COLS,
  localparam int DEPTH = ROWS * COLS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             clear_start,
  input  logic             read_start,
  pixel_frame_stream_if.master os,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q;
  logic             all_q;
  logic             pend_q;
  logic [AW-1:0]    pidx_q;
  logic [1:0]       fill_q;
  logic [PIX_W-1:0] bdat_q [2];
  logic [AW-1:0]    bidx_q [2];

  logic [PIX_W-1:0] rdata;
  logic [PIX_W-1:0] hdat;
  logic [AW-1:0]    hidx;
  logic             vld, fire, push, pop, slot;
  logic             issue, in_rng;
  logic             ram_we;
  logic [AW-1:0]    ram_wa;
  logic [PIX_W-1:0] ram_wd;

  frame_ram #(
    .PIX_W(PIX_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .waddr(ram_wa),
    .wdata(ram_wd),
    .re   (issue),
    .raddr(cnt_q),
    .rdata(rdata)
  );

  assign in_rng = {1'b0, wr_addr} < (AW + 1)'(DEPTH);
  assign ram_we = (state_q == CLEAR) | (wr_en & in_rng);
  assign ram_wa = (state_q == CLEAR) ? cnt_q : wr_addr;
  assign ram_wd = (state_q == CLEAR) ? '0 : wr_data;

  // Held beats plus the read in flight never exceed two.
  assign issue = (state_q == STREAM) & ~all_q &
                 ((fill_q == 2'd0) |
                  ((fill_q == 2'd1) & ~pend_q));

  // With the buffer empty the RAM output is presented directly.
  assign vld  = (fill_q != 2'd0) | pend_q;
  assign hdat = (fill_q != 2'd0) ? bdat_q[0] : rdata;
  assign hidx = (fill_q != 2'd0) ? bidx_q[0] : pidx_q;
  assign fire = vld & os.out_ready;
  assign pop  = fire & (fill_q != 2'd0);
  assign push = pend_q & ~((fill_q == 2'd0) & os.out_ready);
  assign slot = (fill_q == 2'd2) | ((fill_q == 2'd1) & ~pop);

  assign os.out_valid = vld;
  assign os.out_data  = vld ? hdat : '0;
  assign os.out_index = vld ? hidx : '0;
  assign os.out_last  = vld & (hidx == LAST);

  assign busy = (state_q == CLEAR) | (state_q == STREAM);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (clear_start)     state_d = CLEAR;
        else if (read_start) state_d = STREAM;
      end
      CLEAR:   if (cnt_q == LAST) state_d = DONE;
      STREAM:  if (fire & os.out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      all_q   <= 1'b0;
      pend_q  <= 1'b0;
      pidx_q  <= '0;
      fill_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      if (issue) pidx_q <= cnt_q;
      fill_q  <= fill_q + {1'b0, push} - {1'b0, pop};
      if ((state_q == CLEAR) | issue) begin
        if (cnt_q == LAST) all_q <= 1'b1;
        else               cnt_q <= cnt_q + 1'b1;
      end else if (state_q == IDLE) begin
        cnt_q <= '0;
        all_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (pop) begin
      bdat_q[0] <= bdat_q[1];
      bidx_q[0] <= bidx_q[1];
    end
    if (push) begin
      bdat_q[slot] <= rdata;
      bidx_q[slot] <= pidx_q;
    end
  end

endmodule
